// File: rtl/gate_array_pkg.sv
// Shared op codes and combinational helpers for the gate array.
package gate_array_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_XNOR);
    endfunction

    // Codes 6/7 can never reach op_cur, so the default is unreachable in practice.
    function automatic logic gate_eval(input logic [OP_W-1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop pad synchroniser followed by a consecutive-cycle debounce filter.
module debounce_bit #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_array_sync.sv
// CHANNELS debounced two-input gates sharing one runtime-selectable function,
// with registered outputs, a warm-up valid flag and a saturating toggle counter.
module gate_array_sync
    import gate_array_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic [OP_W-1:0]     op_in,
    input  logic                op_load,
    output logic [CHANNELS-1:0] y,
    output logic [OP_W-1:0]     op_cur,
    output logic                op_err,
    output logic                y_valid,
    output logic [CNT_W-1:0]    toggle_cnt
);

    localparam int WW = $clog2(DEB_CYCLES + 2) + 1;

    logic [CHANNELS-1:0] a_stable;
    logic [CHANNELS-1:0] b_stable;
    logic [CHANNELS-1:0] y_next;
    logic [WW-1:0]       warm;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
            .clk    (clk),
            .rst    (rst),
            .pin    (a[i]),
            .stable (a_stable[i])
        );
        debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
            .clk    (clk),
            .rst    (rst),
            .pin    (b[i]),
            .stable (b_stable[i])
        );
        assign y_next[i] = gate_eval(op_cur, a_stable[i], b_stable[i]);
    end

    // An illegal load keeps the previous function running and only flags the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cur <= OP_AND;
            op_err <= 1'b0;
        end else if (op_load) begin
            if (op_is_legal(op_in)) begin
                op_cur <= op_in;
            end else begin
                op_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y          <= '0;
            toggle_cnt <= '0;
        end else if (en) begin
            y <= y_next;
            if ((y_next != y) && (toggle_cnt != {CNT_W{1'b1}})) begin
                toggle_cnt <= toggle_cnt + 1'b1;
            end
        end
    end

    // warm tracks edges since reset release; valid rises on edge DEB_CYCLES+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm    <= '0;
            y_valid <= 1'b0;
        end else begin
            if (!y_valid) begin
                warm <= warm + 1'b1;
            end
            if (warm == WW'(DEB_CYCLES + 1)) begin
                y_valid <= 1'b1;
            end
        end
    end

endmodule
